// File: rtl/led_blinker.sv
// led_blinker: multi-channel LED driver with blink, PWM and one-shot modes.
// A single-slot valid/ready port reprograms one channel at a time.
module led_blinker #(
  parameter int WIDTH    = 22,
  parameter int CHANNELS = 5,
  localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                CLK,
  input  logic                RESETN,
  input  logic                EN,
  input  logic                CFG_VALID,
  output logic                CFG_READY,
  input  logic [CW-1:0]       CFG_CH,
  input  logic [1:0]          CFG_MODE,
  input  logic [WIDTH-1:0]    CFG_PERIOD,
  input  logic [WIDTH-1:0]    CFG_DUTY,
  output logic [CHANNELS-1:0] LED,
  output logic [CHANNELS-1:0] TICK
);

  typedef enum logic [1:0] {
    M_OFF   = 2'd0,
    M_BLINK = 2'd1,
    M_PWM   = 2'd2,
    M_ONE   = 2'd3
  } mode_e;

  // Default period makes each LED follow the MSB of a free-running counter.
  localparam logic [WIDTH-1:0] P_DEF = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  logic r_ready;
  logic w_xfer;

  assign w_xfer    = CFG_VALID & r_ready;
  assign CFG_READY = r_ready;

  // Ready drops for exactly one cycle after every accepted transfer.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_ready <= 1'b0;
    end else begin
      r_ready <= ~w_xfer;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    mode_e            r_mode;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_per;
    logic [WIDTH-1:0] r_duty;
    logic             r_led;
    logic             w_sel;
    logic             w_act;
    logic             w_wrap;
    logic             w_led;

    assign w_sel  = w_xfer && (CFG_CH == CW'(g));
    assign w_act  = (r_mode != M_OFF);
    assign w_wrap = w_act & EN & (r_cnt == r_per);

    always_comb begin
      w_led = 1'b0;
      unique case (r_mode)
        M_PWM:          w_led = (r_cnt < r_duty);
        M_BLINK, M_ONE: w_led = r_led;
        default:        w_led = 1'b0;
      endcase
    end

    assign LED[g]  = w_led;
    assign TICK[g] = w_wrap;

    // A commit wins over a coincident wrap: no toggle, no one-shot end.
    always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
        r_mode <= M_BLINK;
        r_cnt  <= '0;
        r_per  <= P_DEF;
        r_duty <= '0;
        r_led  <= 1'b0;
      end else if (w_sel) begin
        r_mode <= mode_e'(CFG_MODE);
        r_cnt  <= '0;
        r_per  <= CFG_PERIOD;
        r_duty <= CFG_DUTY;
        r_led  <= (CFG_MODE == M_ONE);
      end else if (EN && w_act) begin
        if (w_wrap) begin
          r_cnt <= '0;
          if (r_mode == M_BLINK) begin
            r_led <= ~r_led;
          end
          if (r_mode == M_ONE) begin
            r_led  <= 1'b0;
            r_mode <= M_OFF;
          end
        end else begin
          r_cnt <= r_cnt + ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_led_blinker.sv
// tb_led_blinker: directed vectors, corner sequences and random traffic
// checked against an enabled-cycle-count model of each channel.
module tb_led_blinker;
  localparam int W  = 4;
  localparam int NC = 5;

  logic          CLK = 1'b0;
  logic          RESETN;
  logic          EN;
  logic          CFG_VALID;
  logic          CFG_READY;
  logic [2:0]    CFG_CH;
  logic [1:0]    CFG_MODE;
  logic [W-1:0]  CFG_PERIOD;
  logic [W-1:0]  CFG_DUTY;
  logic [NC-1:0] LED;
  logic [NC-1:0] TICK;

  always #5 CLK = ~CLK;

  led_blinker #(.WIDTH(W), .CHANNELS(NC)) dut (
    .CLK(CLK),
    .RESETN(RESETN),
    .EN(EN),
    .CFG_VALID(CFG_VALID),
    .CFG_READY(CFG_READY),
    .CFG_CH(CFG_CH),
    .CFG_MODE(CFG_MODE),
    .CFG_PERIOD(CFG_PERIOD),
    .CFG_DUTY(CFG_DUTY),
    .LED(LED),
    .TICK(TICK)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: each channel is described by the number of enabled cycles
  // since its last commit; cnt, led and tick are derived arithmetically.
  int     m_mode[NC];
  int     m_per[NC];
  int     m_duty[NC];
  longint m_n[NC];
  bit     m_rdy;

  typedef struct {
    bit v;
    int ch;
    int md;
    int per;
    int du;
    bit en;
    int obs;
    bit led;
    bit tick;
    bit rdy;
  } vec_t;

  vec_t tv[15];

  function automatic vec_t mk(bit v, int ch, int md, int per, int du,
                              bit en, int obs, bit led, bit tick, bit rdy);
    vec_t r;
    r.v = v; r.ch = ch; r.md = md; r.per = per; r.du = du;
    r.en = en; r.obs = obs; r.led = led; r.tick = tick; r.rdy = rdy;
    return r;
  endfunction

  function automatic int m_cnt(int c);
    if (m_mode[c] == 0) return 0;
    return int'(m_n[c] % longint'(m_per[c] + 1));
  endfunction

  function automatic bit m_led(int c);
    case (m_mode[c])
      1: return ((m_n[c] / longint'(m_per[c] + 1)) % 2) == 1;
      2: return m_cnt(c) < m_duty[c];
      3: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit m_tick(int c);
    return (m_mode[c] != 0) && (EN == 1'b1) && (m_cnt(c) == m_per[c]);
  endfunction

  function automatic logic [NC-1:0] m_leds();
    logic [NC-1:0] r;
    for (int c = 0; c < NC; c++) r[c] = m_led(c);
    return r;
  endfunction

  function automatic logic [NC-1:0] m_ticks();
    logic [NC-1:0] r;
    for (int c = 0; c < NC; c++) r[c] = m_tick(c);
    return r;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      m_mode[c] = 1;
      m_per[c]  = (1 << (W - 1)) - 1;
      m_duty[c] = 0;
      m_n[c]    = 0;
    end
    m_rdy = 1'b0;
  endtask

  task automatic model_step();
    bit xfer;
    xfer = CFG_VALID && m_rdy;
    for (int c = 0; c < NC; c++) begin
      if (xfer && int'(CFG_CH) == c) begin
        m_mode[c] = int'(CFG_MODE);
        m_per[c]  = int'(CFG_PERIOD);
        m_duty[c] = int'(CFG_DUTY);
        m_n[c]    = 0;
      end else if (EN && m_mode[c] != 0) begin
        m_n[c]++;
        if (m_mode[c] == 3 && m_n[c] == longint'(m_per[c] + 1)) begin
          m_mode[c] = 0;
          m_n[c]    = 0;
        end
      end
    end
    m_rdy = !xfer;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(bit v, int ch, int md, int per, int du);
    CFG_VALID  = v;
    CFG_CH     = 3'(ch);
    CFG_MODE   = 2'(md);
    CFG_PERIOD = W'(per);
    CFG_DUTY   = W'(du);
  endtask

  task automatic sample();
    #1;
    chk("model_led", LED, m_leds());
    chk("model_tick", TICK, m_ticks());
    chk("model_ready", CFG_READY, m_rdy);
  endtask

  task automatic advance();
    @(posedge CLK);
    model_step();
    @(negedge CLK);
  endtask

  task automatic step();
    sample();
    advance();
  endtask

  task automatic default_blink_check();
    for (int k = 0; k < 32; k++) begin
      sample();
      chk("dflt_led0", LED[0], (k % 16) >= 8);
      chk("dflt_tick0", TICK[0], (k % 8) == 7);
      advance();
    end
  endtask

  initial begin
    tv[0]  = mk(1, 1, 2, 3, 2, 1, 1, 0, 0, 1);
    tv[1]  = mk(0, 1, 2, 3, 2, 1, 1, 1, 0, 0);
    tv[2]  = mk(0, 1, 2, 3, 2, 1, 1, 1, 0, 1);
    tv[3]  = mk(0, 1, 2, 3, 2, 1, 1, 0, 0, 1);
    tv[4]  = mk(0, 1, 2, 3, 2, 1, 1, 0, 1, 1);
    tv[5]  = mk(0, 1, 2, 3, 2, 1, 1, 1, 0, 1);
    tv[6]  = mk(0, 1, 2, 3, 2, 1, 1, 1, 0, 1);
    tv[7]  = mk(0, 1, 2, 3, 2, 1, 1, 0, 0, 1);
    tv[8]  = mk(1, 1, 2, 3, 5, 1, 1, 0, 1, 1);
    tv[9]  = mk(0, 1, 2, 3, 5, 1, 1, 1, 0, 0);
    tv[10] = mk(0, 1, 2, 3, 5, 1, 1, 1, 0, 1);
    tv[11] = mk(0, 1, 2, 3, 5, 1, 1, 1, 0, 1);
    tv[12] = mk(0, 1, 2, 3, 5, 1, 1, 1, 1, 1);
    tv[13] = mk(0, 1, 2, 3, 5, 1, 1, 1, 0, 1);
    tv[14] = mk(0, 1, 2, 3, 5, 0, 1, 1, 0, 1);

    RESETN = 1'b0;
    EN     = 1'b1;
    drive(0, 0, 0, 0, 0);
    model_reset();
    @(negedge CLK);
    @(negedge CLK);
    #1;
    chk("rst_led", LED, 0);
    chk("rst_tick", TICK, 0);
    chk("rst_ready", CFG_READY, 0);
    @(negedge CLK);
    RESETN = 1'b1;
    default_blink_check();

    foreach (tv[i]) begin
      drive(tv[i].v, tv[i].ch, tv[i].md, tv[i].per, tv[i].du);
      EN = tv[i].en;
      sample();
      chk("tv_led", LED[tv[i].obs], tv[i].led);
      chk("tv_tick", TICK[tv[i].obs], tv[i].tick);
      chk("tv_ready", CFG_READY, tv[i].rdy);
      advance();
    end
    EN = 1'b1;

    drive(1, 2, 3, 5, 0);
    step();
    drive(0, 0, 0, 0, 0);
    for (int k = 0; k < 12; k++) begin
      sample();
      chk("os_led2", LED[2], k < 6);
      chk("os_tick2", TICK[2], k == 5);
      advance();
    end

    drive(1, 6, 3, 1, 1);
    for (int k = 0; k < 4; k++) begin
      sample();
      chk("hs_ready", CFG_READY, (k % 2) == 0);
      advance();
    end
    drive(0, 0, 0, 0, 0);

    drive(1, 3, 1, 2, 0);
    step();
    drive(0, 0, 0, 0, 0);
    step();
    step();
    drive(1, 3, 1, 2, 0);
    sample();
    chk("col_tick3", TICK[3], 1);
    chk("col_led3", LED[3], 0);
    advance();
    drive(0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      sample();
      chk("col_tick3_after", TICK[3], k == 2);
      chk("col_led3_after", LED[3], 0);
      advance();
    end
    sample();
    chk("col_led3_toggle", LED[3], 1);
    advance();

    EN = 1'b0;
    for (int k = 0; k < 10; k++) begin
      sample();
      chk("en0_tick", TICK, 0);
      advance();
    end
    EN = 1'b1;

    for (int k = 0; k < 800; k++) begin
      EN = ($urandom_range(0, 9) != 0);
      drive($urandom_range(0, 3) == 0, int'($urandom_range(0, 7)),
            int'($urandom_range(0, 3)),
            ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, 5)),
            int'($urandom_range(0, 7)));
      step();
    end

    EN = 1'b1;
    drive(0, 0, 0, 0, 0);
    step();
    drive(1, 2, 3, 9, 0);
    step();
    drive(0, 0, 0, 0, 0);
    step();
    step();
    step();
    #2;
    RESETN = 1'b0;
    #1;
    chk("arst_led", LED, 0);
    chk("arst_tick", TICK, 0);
    chk("arst_ready", CFG_READY, 0);
    model_reset();
    @(negedge CLK);
    @(negedge CLK);
    RESETN = 1'b1;
    default_blink_check();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
